// File: rtl/serial_bit_subtractor_pkg.sv
// Shared types and elaboration helpers for the serial bit subtractor.
package serial_bit_subtractor_pkg;

    typedef enum logic {
        IDLE = 1'b0,
        RUN  = 1'b1
    } state_e;

    function automatic int chunks_f(input int width, input int bpc);
        return width / bpc;
    endfunction

    // A single-chunk configuration still needs a 1-bit counter.
    function automatic int cnt_w_f(input int chunks);
        return (chunks > 1) ? $clog2(chunks) : 1;
    endfunction

    function automatic bit params_ok_f(input int width, input int bpc);
        return (bpc > 0) && (width % bpc == 0);
    endfunction

endpackage

// File: rtl/serial_bit_subtractor_chunk.sv
// Combinational chunk cell: popcount of a chunk, then a ripple borrow-chain subtract.
module subtrator_chunk #(
    parameter int BITS_PER_CYCLE = 1,
    parameter int RESULT_W       = 4
) (
    input  logic [RESULT_W-1:0]       minuend_i,
    input  logic [BITS_PER_CYCLE-1:0] chunk_i,
    output logic [RESULT_W-1:0]       diff_o,
    output logic                      borrow_o
);
    localparam int KW = $clog2(BITS_PER_CYCLE + 1);
    // Chain runs wide enough that a popcount above 2^RESULT_W-1 still borrows.
    localparam int EW = ((KW > RESULT_W) ? KW : RESULT_W) + 1;

    logic [KW-1:0] k;
    logic [EW-1:0] m_ext;
    logic [EW-1:0] k_ext;
    logic [EW:0]   bc;

    always_comb begin
        k = '0;
        for (int i = 0; i < BITS_PER_CYCLE; i++) begin
            k = k + KW'(chunk_i[i]);
        end
        m_ext = EW'(minuend_i);
        k_ext = EW'(k);
        bc    = '0;
        for (int i = 0; i < EW; i++) begin
            bc[i+1] = (~m_ext[i] & k_ext[i]) | (~(m_ext[i] ^ k_ext[i]) & bc[i]);
        end
        diff_o   = m_ext[RESULT_W-1:0] ^ k_ext[RESULT_W-1:0] ^ bc[RESULT_W-1:0];
        borrow_o = bc[EW];
    end

endmodule

// File: rtl/serial_bit_subtractor.sv
// Sequential subtractor: decrements init by one per selected operand bit, BITS_PER_CYCLE bits per clock.
module serial_bit_subtractor
    import serial_bit_subtractor_pkg::*;
#(
    parameter int WIDTH          = 8,
    parameter int RESULT_W       = 4,
    parameter int BITS_PER_CYCLE = 1
) (
    input  logic                clk,
    input  logic                rst_n,
    input  logic                start,
    input  logic [WIDTH-1:0]    operand,
    input  logic [RESULT_W-1:0] init,
    input  logic                mode,
    output logic                busy,
    output logic                done,
    output logic [RESULT_W-1:0] result,
    output logic                underflow
);
    localparam int CHUNKS = chunks_f(WIDTH, BITS_PER_CYCLE);
    localparam int CNT_W  = cnt_w_f(CHUNKS);
    localparam logic [CNT_W-1:0] LAST = CNT_W'(CHUNKS - 1);

    generate
        if (!params_ok_f(WIDTH, BITS_PER_CYCLE)) begin : g_bad_params
            $error("WIDTH must be a multiple of BITS_PER_CYCLE");
        end
    endgenerate

    state_e              state_q;
    logic [WIDTH-1:0]    sreg_q;
    logic [CNT_W-1:0]    cnt_q;
    logic [RESULT_W-1:0] result_q;
    logic                uflow_q;
    logic                busy_q;
    logic                done_q;

    logic [RESULT_W-1:0] result_d;
    logic                borrow_d;

    subtrator_chunk #(
        .BITS_PER_CYCLE(BITS_PER_CYCLE),
        .RESULT_W      (RESULT_W)
    ) u_chunk (
        .minuend_i(result_q),
        .chunk_i  (sreg_q[BITS_PER_CYCLE-1:0]),
        .diff_o   (result_d),
        .borrow_o (borrow_d)
    );

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q  <= IDLE;
            sreg_q   <= '0;
            cnt_q    <= '0;
            result_q <= '0;
            uflow_q  <= 1'b0;
            busy_q   <= 1'b0;
            done_q   <= 1'b0;
        end else begin
            done_q <= 1'b0;
            case (state_q)
                IDLE: begin
                    if (start) begin
                        // mode=1 counts clear bits, so invert once here and always count ones.
                        sreg_q   <= mode ? ~operand : operand;
                        result_q <= init;
                        uflow_q  <= 1'b0;
                        cnt_q    <= '0;
                        busy_q   <= 1'b1;
                        state_q  <= RUN;
                    end
                end
                RUN: begin
                    result_q <= result_d;
                    uflow_q  <= uflow_q | borrow_d;
                    sreg_q   <= sreg_q >> BITS_PER_CYCLE;
                    cnt_q    <= cnt_q + 1'b1;
                    if (cnt_q == LAST) begin
                        cnt_q   <= '0;
                        busy_q  <= 1'b0;
                        done_q  <= 1'b1;
                        state_q <= IDLE;
                    end
                end
                default: state_q <= IDLE;
            endcase
        end
    end

    assign busy      = busy_q;
    assign done      = done_q;
    assign result    = result_q;
    assign underflow = uflow_q;

endmodule

// File: tb/tb_serial_bit_subtractor.sv
// Bench for serial_bit_subtractor: default build plus a BITS_PER_CYCLE=4 build.
module tb_serial_bit_subtractor;

    logic       clk = 1'b0;
    logic       rst_n;
    logic       start;
    logic       start4;
    logic [7:0] operand;
    logic [3:0] init;
    logic       mode;

    logic       busy, done, underflow;
    logic [3:0] result;
    logic       busy4, done4, underflow4;
    logic [3:0] result4;

    always #5 clk = ~clk;

    serial_bit_subtractor dut (
        .clk(clk), .rst_n(rst_n), .start(start), .operand(operand), .init(init), .mode(mode),
        .busy(busy), .done(done), .result(result), .underflow(underflow)
    );

    serial_bit_subtractor #(.WIDTH(8), .RESULT_W(4), .BITS_PER_CYCLE(4)) dut4 (
        .clk(clk), .rst_n(rst_n), .start(start4), .operand(operand), .init(init), .mode(mode),
        .busy(busy4), .done(done4), .result(result4), .underflow(underflow4)
    );

    typedef struct {
        logic [3:0] init;
        logic [7:0] op;
        logic       mode;
        logic [3:0] res;
        logic       uf;
    } vec_t;

    typedef struct {
        logic [3:0] res;
        logic       uf;
    } exp_t;

    exp_t sb_q[$];
    int   errors = 0;
    int   checks = 0;

    task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %0d expected %0d", nm, act, exp);
        end
    endtask

    // Whole-operand reference: total count against init, independent of chunking.
    function automatic vec_t model_f(input logic [3:0] i, input logic [7:0] op, input logic m);
        vec_t v;
        int   tot;
        tot    = $countones(m ? ~op : op);
        v.init = i;
        v.op   = op;
        v.mode = m;
        v.res  = 4'(int'(i) - tot);
        v.uf   = (tot > int'(i));
        return v;
    endfunction

    task automatic pop_exp(input string nm, output exp_t e);
        if (sb_q.size() == 0) begin
            chk({nm, ".sb_empty"}, 1, 0);
            e.res = 'x;
            e.uf  = 'x;
        end else begin
            e = sb_q.pop_front();
        end
    endtask

    task automatic run_default(input vec_t v, input string nm);
        exp_t e;
        int   n;
        @(negedge clk);
        init    = v.init;
        operand = v.op;
        mode    = v.mode;
        start   = 1'b1;
        sb_q.push_back('{v.res, v.uf});
        @(negedge clk);
        start = 1'b0;
        chk({nm, ".busy_run"}, busy, 1);
        chk({nm, ".done_run"}, done, 0);
        n = 0;
        while (!done && n < 20) begin
            @(negedge clk);
            n++;
        end
        chk({nm, ".latency"}, n, 8);
        pop_exp(nm, e);
        chk({nm, ".result"}, result, e.res);
        chk({nm, ".underflow"}, underflow, e.uf);
        chk({nm, ".busy_done"}, busy, 0);
        @(negedge clk);
        chk({nm, ".done_fall"}, done, 0);
        chk({nm, ".uf_hold"}, underflow, e.uf);
        chk({nm, ".res_hold"}, result, e.res);
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin
        vec_t tbl[8];
        vec_t v;
        exp_t e;
        int   n;
        int   pulses;

        tbl[0] = '{4'd15, 8'b1011_0110, 1'b0, 4'd10, 1'b0};
        tbl[1] = '{4'd3,  8'hFF,        1'b0, 4'd11, 1'b1};
        tbl[2] = '{4'd4,  8'h0F,        1'b1, 4'd0,  1'b0};
        tbl[3] = '{4'd0,  8'h00,        1'b0, 4'd0,  1'b0};
        tbl[4] = '{4'd0,  8'h00,        1'b1, 4'd8,  1'b1};
        tbl[5] = '{4'd15, 8'hFF,        1'b0, 4'd7,  1'b0};
        tbl[6] = '{4'd7,  8'hFF,        1'b0, 4'd15, 1'b1};
        tbl[7] = '{4'd8,  8'hAA,        1'b1, 4'd4,  1'b0};

        rst_n = 1'b0; start = 1'b0; start4 = 1'b0;
        operand = 8'h5A; init = 4'd9; mode = 1'b0;
        #2;
        chk("rst.busy", busy, 0);
        chk("rst.done", done, 0);
        chk("rst.result", result, 0);
        chk("rst.underflow", underflow, 0);
        chk("rst.busy4", busy4, 0);
        chk("rst.result4", result4, 0);
        @(negedge clk);
        rst_n = 1'b1;

        foreach (tbl[i]) run_default(tbl[i], $sformatf("tbl%0d", i));

        for (int i = 0; i < 6; i++) begin
            v = model_f(4'($urandom_range(0, 15)), 8'($urandom), 1'($urandom_range(0, 1)));
            run_default(v, $sformatf("rnd%0d", i));
        end

        // start and input changes during RUN must be ignored
        @(negedge clk);
        init = 4'd9; operand = 8'h03; mode = 1'b0; start = 1'b1;
        sb_q.push_back('{4'd7, 1'b0});
        @(negedge clk);
        start = 1'b0;
        n = 0;
        while (!done && n < 20) begin
            @(negedge clk);
            n++;
            if (n == 3) begin
                start = 1'b1; operand = 8'hFF; init = 4'd0; mode = 1'b1;
            end
            if (n == 5) start = 1'b0;
        end
        chk("ign.latency", n, 8);
        pop_exp("ign", e);
        chk("ign.result", result, e.res);
        chk("ign.underflow", underflow, e.uf);
        pulses = 0;
        repeat (10) begin
            @(negedge clk);
            if (done) pulses++;
        end
        chk("ign.extra_done", pulses, 0);
        chk("ign.busy_idle", busy, 0);
        mode = 1'b0;

        // reset in the middle of a run
        @(negedge clk);
        init = 4'd2; operand = 8'hFF; mode = 1'b0; start = 1'b1;
        @(negedge clk);
        start = 1'b0;
        repeat (4) @(negedge clk);
        chk("mid.result_pre", result, 14);
        chk("mid.uf_pre", underflow, 1);
        chk("mid.busy_pre", busy, 1);
        #2 rst_n = 1'b0;
        #1;
        chk("mid.busy", busy, 0);
        chk("mid.done", done, 0);
        chk("mid.result", result, 0);
        chk("mid.underflow", underflow, 0);
        @(negedge clk);
        rst_n = 1'b1;
        pulses = 0;
        repeat (12) begin
            @(negedge clk);
            if (done) pulses++;
        end
        chk("mid.no_done", pulses, 0);
        chk("mid.busy_after", busy, 0);
        run_default('{4'd2, 8'h01, 1'b0, 4'd1, 1'b0}, "mid_next");

        // 4-bit chunks and back-to-back accept in the done cycle
        @(negedge clk);
        init = 4'd5; operand = 8'hF1; mode = 1'b0; start4 = 1'b1;
        sb_q.push_back('{4'd0, 1'b0});
        @(negedge clk);
        start4 = 1'b0;
        chk("b2b.busy4", busy4, 1);
        n = 0;
        while (!done4 && n < 10) begin
            @(negedge clk);
            n++;
        end
        chk("b2b.latency1", n, 2);
        pop_exp("b2b1", e);
        chk("b2b.result1", result4, e.res);
        chk("b2b.uf1", underflow4, e.uf);
        start4 = 1'b1; init = 4'd0; operand = 8'h10;
        sb_q.push_back('{4'd15, 1'b1});
        @(negedge clk);
        start4 = 1'b0;
        chk("b2b.done_fall", done4, 0);
        chk("b2b.reaccept", busy4, 1);
        n = 0;
        while (!done4 && n < 10) begin
            @(negedge clk);
            n++;
        end
        chk("b2b.latency2", n, 2);
        pop_exp("b2b2", e);
        chk("b2b.result2", result4, e.res);
        chk("b2b.uf2", underflow4, e.uf);
        @(negedge clk);
        chk("b2b.done_once", done4, 0);

        chk("sb.drained", sb_q.size(), 0);
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
